// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/result bundle for the iterative multiply/divide unit.
//
// Handshake: the master raises start with op/a/b valid. The unit accepts on a
// rising edge where start is high and busy is low; op/a/b are don't-care
// afterwards. busy acts as the inverted ready. done pulses for one cycle when
// hi/lo (and div_by_zero) have been loaded with the result.
//
// Signals:
//   start       master->slave  request to begin an operation
//   op[1:0]     master->slave  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a[31:0]     master->slave  multiplicand / dividend
//   b[31:0]     master->slave  multiplier / divisor
//   busy        slave->master  operation in progress
//   done        slave->master  one-cycle result pulse
//   hi[31:0]    slave->master  product[63:32] or remainder
//   lo[31:0]    slave->master  product[31:0] or quotient
//   div_by_zero slave->master  last divide had b == 0
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- 32-bit iterative multiply/divide unit with HI/LO result
// registers. Operands are reduced to magnitudes at accept, 32 radix-2
// iterations run in CALC (shift-add or restoring shift-subtract), and FIX
// applies the sign correction and loads hi/lo. 33 cycles accept-to-done.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-high
//   bus      muldiv_unit_if.slave request/result bundle
//   state_o  current FSM state (debug observation)
module muldiv_unit (
    input  logic             clock,
    input  logic             reset,
    muldiv_unit_if.slave     bus,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        is_div_q, is_div_d;
    logic        neg_q_q, neg_q_d;     // product / quotient negative
    logic        neg_r_q, neg_r_d;     // remainder negative
    logic        zdiv_q, zdiv_d;       // divide with b == 0
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;   // product high half / partial remainder
    logic [31:0] acc_lo_q, acc_lo_d;   // multiplier bits / dividend->quotient
    logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] sum;
    logic [32:0] shifted;
    logic        div_ge;
    logic [63:0] prod_fix;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            zdiv_q   <= 1'b0;
            cnt_q    <= 5'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            opnd_q   <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            zdiv_q   <= zdiv_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        zdiv_d   = zdiv_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        a_mag    = 32'd0;
        b_mag    = 32'd0;
        sum      = 33'd0;
        shifted  = 33'd0;
        div_ge   = 1'b0;
        prod_fix = 64'd0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // op[0] selects signed: work on magnitudes, fix signs at the end.
                    a_mag    = (bus.op[0] && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
                    b_mag    = (bus.op[0] && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
                    is_div_d = bus.op[1];
                    neg_q_d  = bus.op[0] & (bus.a[31] ^ bus.b[31]);
                    neg_r_d  = bus.op[0] & bus.a[31];
                    zdiv_d   = bus.op[1] && (bus.b == 32'd0);
                    acc_hi_d = 32'd0;
                    acc_lo_d = a_mag;
                    opnd_d   = b_mag;
                    cnt_d    = 5'd0;
                    dbz_d    = 1'b0;
                    state_d  = CALC;
                end
            end

            CALC: begin
                if (!is_div_q) begin
                    // Shift-add: the carry out of the add shifts into the high half.
                    sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
                    {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[31:1]};
                end else begin
                    // Restoring step: the partial remainder stays below the
                    // divisor, so a 32-bit subtraction result is exact.
                    shifted  = {acc_hi_q, acc_lo_q[31]};
                    div_ge   = shifted >= {1'b0, opnd_q};
                    acc_hi_d = div_ge ? (shifted[31:0] - opnd_q) : shifted[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ge};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (!is_div_q) begin
                    prod_fix = neg_q_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};
                    hi_d     = prod_fix[63:32];
                    lo_d     = prod_fix[31:0];
                end else if (zdiv_q) begin
                    hi_d  = 32'd0;
                    lo_d  = 32'd0;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = neg_q_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
                    hi_d = neg_r_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed vector table plus hand-written sequences for
// back-to-back issue, divide-by-zero flag clearing, ignored start while busy
// and mid-operation reset.
module tb_muldiv_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] state_o;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // scoreboard: {div_by_zero, hi, lo}
    logic [64:0] exp_q[$];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[$];

    always @(negedge clock) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                           input logic dbz);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = dbz;
        vecs.push_back(v);
    endtask

    // driver: hold start across one rising edge, then scramble the operands
    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
        exp_q.push_back({edbz, ehi, elo});
        check("accept_busy", 64'(bus.busy), 64'd1);
    endtask

    // waits for done (bounded); optional one-cycle start glitch at cycle glitch_at
    task automatic wait_done(input string name, input int glitch_at);
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        logic [64:0] e;
        int          cyc;
        int          bc;
        bit          got;
        bit          hold_ok;
        hold_hi = bus.hi;
        hold_lo = bus.lo;
        cyc     = 0;
        bc      = 1;
        got     = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            if (bus.busy) bc++;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.hi !== hold_hi || bus.lo !== hold_lo) hold_ok = 1'b0;
                if (cyc == glitch_at) begin
                    bus.start = 1'b1;
                    bus.op    = 2'b00;
                    bus.a     = 32'h55;
                    bus.b     = 32'h3;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check({name, "_done_seen"}, 64'(got), 64'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        if (got) begin
            check({name, "_latency"}, 64'(cyc), 64'd33);
            check({name, "_busy_cycles"}, 64'(bc), 64'd33);
            check({name, "_hold"}, 64'(hold_ok), 64'd1);
            check({name, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
            check({name, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
            check({name, "_dbz"}, 64'(bus.div_by_zero), 64'(e[64]));
        end
    endtask

    initial begin
        int d0;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;

        add_vec("multu_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        add_vec("multu_6x7",  2'b00, 32'd6,        32'd7,        32'h00000000, 32'd42,       1'b0);
        add_vec("mult_m3x5",  2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        add_vec("mult_minsq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        add_vec("mult_7xm1",  2'b01, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0);
        add_vec("divu_1000",  2'b10, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0);
        add_vec("div_m7_2",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        add_vec("div_7_m2",   2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        add_vec("div_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        add_vec("divu_big",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        add_vec("divu_zero",  2'b10, 32'd100,      32'd0,        32'h00000000, 32'h00000000, 1'b1);
        add_vec("div_zero",   2'b11, 32'hFFFFFFFB, 32'd0,        32'h00000000, 32'h00000000, 1'b1);
        add_vec("multu_sh",   2'b00, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0);
        add_vec("divu_by1",   2'b10, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0);

        // reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check("rst_state", 64'(state_o), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // vector table
        foreach (vecs[i]) begin
            accept(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
            wait_done(vecs[i].name, -1);
            @(negedge clock);
        end

        // back-to-back: start re-raised while done is high
        accept(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        wait_done("b2b_mult", -1);
        accept(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        wait_done("b2b_div", -1);
        @(negedge clock);

        // div_by_zero clears on the next accept edge
        accept(2'b10, 32'd100, 32'd0, 32'd0, 32'd0, 1'b1);
        wait_done("dbz", -1);
        @(negedge clock);
        check("dbz_held", 64'(bus.div_by_zero), 64'd1);
        accept(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        check("dbz_clear", 64'(bus.div_by_zero), 64'd0);
        wait_done("dbz_next", -1);
        @(negedge clock);

        // start pulsed while busy is ignored
        accept(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);
        d0 = done_cnt;
        wait_done("ignore", 5);
        repeat (3) @(posedge clock);
        #1;
        check("ignore_pulses", 64'(done_cnt - d0), 64'd1);
        check("ignore_idle", 64'(bus.busy), 64'd0);
        @(negedge clock);

        // reset in the middle of a multiply
        accept(2'b00, 32'hFFFFFFFF, 32'd3, 32'h2, 32'hFFFFFFFD, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_hi", 64'(bus.hi), 64'd0);
        check("mid_rst_lo", 64'(bus.lo), 64'd0);
        check("mid_rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check("mid_rst_state", 64'(state_o), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        accept(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        wait_done("post_rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
